scan_link_receiver: RTL and testbench

SCAN_LINK_RECEIVER -- requirements
Module: scan_link_receiver

---
 rtl/scan_link_receiver_if.sv | 28 ++
 rtl/scan_link_receiver.sv | 149 ++++++++++++++
 tb/tb_scan_link_receiver.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/scan_link_receiver_if.sv
// Serial scanner link: strobe/data/flag-clear inputs and the decoded command/payload/status outputs.
interface scan_link_receiver_if;
  logic       clkIn;
  logic       dataIn;
  logic       clearFlags;
  logic       cmdValid;
  logic [7:0] cmdCode;
  logic       dataValid;
  logic [7:0] dataByte;
  logic       flagReady;
  logic       flagStart;
  logic       flagFull;
  logic       errUnknown;
  logic       errTimeout;
  logic       busy;

  modport master (
    output clkIn, dataIn, clearFlags,
    input  cmdValid, cmdCode, dataValid, dataByte,
    input  flagReady, flagStart, flagFull, errUnknown, errTimeout, busy
  );

  modport slave (
    input  clkIn, dataIn, clearFlags,
    output cmdValid, cmdCode, dataValid, dataByte,
    output flagReady, flagStart, flagFull, errUnknown, errTimeout, busy
  );
endinterface

// File: rtl/scan_link_receiver.sv
// LSB-first serial command receiver: decodes command bytes, captures the payload after
// command 7, maintains sticky status flags and aborts frames that stall for GAP_MAX cycles.
module scan_link_receiver #(
  parameter int unsigned GAP_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  scan_link_receiver_if.slave  link
);

  localparam int unsigned GW = $clog2(GAP_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [GW-1:0]   gap_inc_c;
  logic [7:0]      byte_c;
  logic            cmd_valid_q, cmd_valid_d;
  logic [7:0]      cmd_code_q, cmd_code_d;
  logic            data_valid_q, data_valid_d;
  logic [7:0]      data_byte_q, data_byte_d;
  logic            err_unknown_q, err_unknown_d;
  logic            err_timeout_q, err_timeout_d;
  logic [2:0]      flags_q, flags_d;
  logic [2:0]      flag_set_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, byte assembly, decode and gap supervision.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    gap_d         = gap_q;
    cmd_valid_d   = 1'b0;
    cmd_code_d    = cmd_code_q;
    data_valid_d  = 1'b0;
    data_byte_d   = data_byte_q;
    err_unknown_d = 1'b0;
    err_timeout_d = 1'b0;
    flag_set_c    = 3'b000;
    byte_c        = {link.dataIn, shift_q};
    gap_inc_c     = GW'(gap_q + GW'(1));

    case (state_q)
      IDLE: begin
        if (link.clkIn) begin
          shift_d[0] = link.dataIn;
          bit_cnt_d  = 3'd1;
          gap_d      = '0;
          state_d    = CMD;
        end
      end
      CMD, DATA: begin
        if (link.clkIn) begin
          gap_d     = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q != 3'd7) begin
            shift_d[bit_cnt_q] = link.dataIn;
          end else if (state_q == DATA) begin
            data_byte_d  = byte_c;
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            case (byte_c)
              8'd2, 8'd3, 8'd4: begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = byte_c;
                flag_set_c  = 3'b001 << (byte_c - 8'd2);
                state_d     = IDLE;
              end
              8'd7: begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = byte_c;
                state_d     = DATA;
              end
              default: begin
                err_unknown_d = 1'b1;
                state_d       = IDLE;
              end
            endcase
          end
        end else if (gap_inc_c == GW'(GAP_MAX)) begin
          err_timeout_d = 1'b1;
          bit_cnt_d     = 3'd0;
          gap_d         = '0;
          state_d       = IDLE;
        end else begin
          gap_d = gap_inc_c;
        end
      end
      default: state_d = IDLE;
    endcase

    // A set in the same cycle as clearFlags wins for that flag only.
    flags_d = flag_set_c | (flags_q & {3{~link.clearFlags}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      gap_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= '0;
      data_valid_q  <= 1'b0;
      data_byte_q   <= '0;
      err_unknown_q <= 1'b0;
      err_timeout_q <= 1'b0;
      flags_q       <= '0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_q         <= gap_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      data_valid_q  <= data_valid_d;
      data_byte_q   <= data_byte_d;
      err_unknown_q <= err_unknown_d;
      err_timeout_q <= err_timeout_d;
      flags_q       <= flags_d;
    end
  end

  assign link.cmdValid   = cmd_valid_q;
  assign link.cmdCode    = cmd_code_q;
  assign link.dataValid  = data_valid_q;
  assign link.dataByte   = data_byte_q;
  assign link.flagReady  = flags_q[0];
  assign link.flagStart  = flags_q[1];
  assign link.flagFull   = flags_q[2];
  assign link.errUnknown = err_unknown_q;
  assign link.errTimeout = err_timeout_q;
  assign link.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_scan_link_receiver.sv
// Directed bench for scan_link_receiver with a scoreboard of expected pulse events.
module tb_scan_link_receiver;

  localparam logic [3:0] K_CMD  = 4'b1000;
  localparam logic [3:0] K_DATA = 4'b0100;
  localparam logic [3:0] K_UNK  = 4'b0010;
  localparam logic [3:0] K_TMO  = 4'b0001;

  typedef struct {
    logic [3:0] kind;
    logic [7:0] code;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;
  exp_t sb[$];
  logic [7:0] m_code;
  logic [7:0] m_data;

  scan_link_receiver_if link();

  scan_link_receiver #(.GAP_MAX(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] kind);
    exp_t e;
    e.kind = kind;
    e.code = m_code;
    e.data = m_data;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the scoreboard, in the expected cycle.
  always @(posedge clk) begin
    logic [3:0] pulses;
    exp_t e;
    #1;
    cyc++;
    pulses = {link.cmdValid, link.dataValid, link.errUnknown, link.errTimeout};
    if (pulses !== 4'b0000) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_pulse observed=%b expected=none cycle=%0d", pulses, cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pulse_kind", 32'(pulses), 32'(e.kind));
        chk("pulse_cycle", 32'(cyc), 32'(e.due));
        chk("pulse_cmdCode", 32'(link.cmdCode), 32'(e.code));
        chk("pulse_dataByte", 32'(link.dataByte), 32'(e.data));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      link.clkIn      = 1'b0;
      link.dataIn     = 1'b0;
      link.clearFlags = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      link.clkIn      = 1'b1;
      link.dataIn     = b[i];
      link.clearFlags = 1'b0;
    end
  endtask

  // Full byte; the expectation is pushed in the cycle bit 7 is driven.
  task automatic send_byte(input logic [7:0] b, input logic clr, input logic [3:0] kind);
    send_bits(b, 7);
    @(negedge clk);
    link.clkIn      = 1'b1;
    link.dataIn     = b[7];
    link.clearFlags = clr;
    push_exp(kind);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_cmdValid"},   32'(link.cmdValid),   32'd0);
    chk({pfx, "_cmdCode"},    32'(link.cmdCode),    32'd0);
    chk({pfx, "_dataValid"},  32'(link.dataValid),  32'd0);
    chk({pfx, "_dataByte"},   32'(link.dataByte),   32'd0);
    chk({pfx, "_flagReady"},  32'(link.flagReady),  32'd0);
    chk({pfx, "_flagStart"},  32'(link.flagStart),  32'd0);
    chk({pfx, "_flagFull"},   32'(link.flagFull),   32'd0);
    chk({pfx, "_errUnknown"}, 32'(link.errUnknown), 32'd0);
    chk({pfx, "_errTimeout"}, 32'(link.errTimeout), 32'd0);
    chk({pfx, "_busy"},       32'(link.busy),       32'd0);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    cyc             = 0;
    m_code          = 8'h00;
    m_data          = 8'h00;
    rst             = 1'b1;
    link.clkIn      = 1'b0;
    link.dataIn     = 1'b0;
    link.clearFlags = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");

    // Command 2 sets flagReady, which then stays set.
    m_code = 8'h02;
    send_byte(8'h02, 1'b0, K_CMD);
    idle(1);
    chk("c2_flagReady", 32'(link.flagReady), 32'd1);
    chk("c2_busy", 32'(link.busy), 32'd0);
    idle(3);
    chk("c2_flagReady_hold", 32'(link.flagReady), 32'd1);

    // Command 7 followed immediately by its payload byte.
    m_code = 8'h07;
    send_byte(8'h07, 1'b0, K_CMD);
    m_data = 8'hA5;
    send_byte(8'hA5, 1'b0, K_DATA);
    idle(1);
    chk("c7_dataByte", 32'(link.dataByte), 32'hA5);
    chk("c7_flags", 32'({link.flagReady, link.flagStart, link.flagFull}), 32'b100);
    chk("c7_busy", 32'(link.busy), 32'd0);

    // Unknown command leaves cmdCode untouched.
    send_byte(8'h05, 1'b0, K_UNK);
    idle(1);
    chk("unk_cmdCode", 32'(link.cmdCode), 32'h07);
    chk("unk_busy", 32'(link.busy), 32'd0);

    // Partial frame aborted by a 4-cycle gap, then a clean command 3.
    send_bits(8'h05, 3);
    idle(1);
    chk("gap_busy_mid", 32'(link.busy), 32'd1);
    idle(2);
    @(negedge clk);
    link.clkIn = 1'b0;
    push_exp(K_TMO);
    idle(1);
    chk("gap_busy_after", 32'(link.busy), 32'd0);
    m_code = 8'h03;
    send_byte(8'h03, 1'b0, K_CMD);
    idle(1);
    chk("c3_flagStart", 32'(link.flagStart), 32'd1);

    // Command 4 coincident with clearFlags: set wins only for flagFull.
    m_code = 8'h04;
    send_byte(8'h04, 1'b1, K_CMD);
    idle(1);
    chk("c4clr_flags", 32'({link.flagReady, link.flagStart, link.flagFull}), 32'b001);
    @(negedge clk);
    link.clearFlags = 1'b1;
    idle(1);
    chk("clr_flagFull", 32'(link.flagFull), 32'd0);

    // Reset mid-frame discards the partial byte silently.
    send_bits(8'h07, 5);
    @(negedge clk);
    link.clkIn = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    m_code = 8'h00;
    m_data = 8'h00;
    chk_all_zero("midrst");
    idle(6);
    m_code = 8'h02;
    send_byte(8'h02, 1'b0, K_CMD);
    idle(1);
    chk("post_rst_flagReady", 32'(link.flagReady), 32'd1);

    idle(4);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
